// File: rtl/rvfpm_pkg.sv
// Shared definitions for the FP offload issue path.
// Contents: default tag width, the seven FP major opcodes, the buffered
// entry layout and an opcode classifier.
// Entry fields are sized for the widest supported configuration; narrower
// instances zero-extend on entry and truncate on exit.
package rvfpm_pkg;

    localparam int X_ID_WIDTH_DEF = 4;
    localparam int ID_W_MAX       = 16;
    localparam int XLEN_MAX       = 64;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;

    typedef struct packed {
        logic [31:0]         instr;
        logic [ID_W_MAX-1:0] id;
        logic [XLEN_MAX-1:0] rs1_data;
        logic [31:0]         mem_data;
    } issue_entry_t;

    function automatic logic is_fp_opcode(input logic [6:0] opc);
        return (opc == OPC_LOAD_FP) || (opc == OPC_STORE_FP) ||
               (opc == OPC_OP_FP)   || (opc == OPC_MADD)     ||
               (opc == OPC_MSUB)    || (opc == OPC_NMSUB)    ||
               (opc == OPC_NMADD);
    endfunction

endpackage

// File: rtl/rvfpm_fifo.sv
// Synchronous FIFO of issue_entry_t.
// Ports: ck (rising edge), rst (sync active-low), flush (clears occupancy,
// wins over push/pop), push/din, pop, head (entry at read pointer), count.
// Storage is not reset; count gates every use of head.
module rvfpm_fifo
    import rvfpm_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  issue_entry_t din,
    input  logic         pop,
    output issue_entry_t head,
    output logic [AW:0]  count
);

    issue_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of two).
    always_ff @(posedge ck) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst && !flush && push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rvfpm_issue_queue.sv
// FP offload issue queue between the core issue interface and the FPU.
// Ports: ck/rst (sync active-low); issue_* offer from core with same-cycle
// issue_ready/issue_accept; flush drops all entries; fpu_ready/enable hand
// one head entry per cycle to the FPU on instruction/id/data_fromXreg/
// data_fromMem; count is current occupancy.
module rvfpm_issue_queue
    import rvfpm_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int X_ID_WIDTH = X_ID_WIDTH_DEF
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [31:0]              issue_instr,
    input  logic [X_ID_WIDTH-1:0]    issue_id,
    input  logic [XLEN-1:0]          issue_rs1_data,
    input  logic [31:0]              issue_mem_data,
    output logic                     issue_accept,
    input  logic                     flush,
    input  logic                     fpu_ready,
    output logic                     enable,
    output logic [31:0]              instruction,
    output logic [X_ID_WIDTH-1:0]    id,
    output logic [XLEN-1:0]          data_fromXreg,
    output logic [31:0]              data_fromMem,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    issue_entry_t din;
    issue_entry_t head;
    logic         push;
    logic         nonempty;
    logic         unused_head;

    assign din.instr    = issue_instr;
    assign din.id       = ID_W_MAX'(issue_id);
    assign din.rs1_data = XLEN_MAX'(issue_rs1_data);
    assign din.mem_data = issue_mem_data;

    // Readiness ignores a same-cycle pop: a full queue refuses even if draining.
    assign issue_ready  = (count < DEPTH_C) && !flush;
    assign push         = issue_valid && issue_ready && is_fp_opcode(issue_instr[6:0]);
    assign issue_accept = push;

    assign nonempty = (count != '0);
    assign enable   = nonempty && fpu_ready && !flush;

    assign instruction   = nonempty ? head.instr                     : '0;
    assign id            = nonempty ? head.id[X_ID_WIDTH-1:0]        : '0;
    assign data_fromXreg = nonempty ? head.rs1_data[XLEN-1:0]        : '0;
    assign data_fromMem  = nonempty ? head.mem_data                  : '0;

    // Upper bits of the widened fields carry no information at this size.
    assign unused_head = ^head;

    rvfpm_fifo #(.DEPTH(DEPTH)) u_fifo (
        .ck    (ck),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (din),
        .pop   (enable),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
module tb_rvfpm_issue_queue;

    logic        ck = 0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [3:0]  issue_id;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_mem_data;
    logic        issue_accept;
    logic        flush;
    logic        fpu_ready;
    logic        enable;
    logic [31:0] instruction;
    logic [3:0]  id;
    logic [31:0] data_fromXreg;
    logic [31:0] data_fromMem;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ck = ~ck;

    rvfpm_issue_queue #(.DEPTH(4), .XLEN(32), .X_ID_WIDTH(4)) dut (
        .ck             (ck),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_instr    (issue_instr),
        .issue_id       (issue_id),
        .issue_rs1_data (issue_rs1_data),
        .issue_mem_data (issue_mem_data),
        .issue_accept   (issue_accept),
        .flush          (flush),
        .fpu_ready      (fpu_ready),
        .enable         (enable),
        .instruction    (instruction),
        .id             (id),
        .data_fromXreg  (data_fromXreg),
        .data_fromMem   (data_fromMem),
        .count          (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let inputs/outputs settle away from it.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [3:0] tag,
                         input logic [31:0] rs1, input logic [31:0] md);
        issue_valid    = 1;
        issue_instr    = ins;
        issue_id       = tag;
        issue_rs1_data = rs1;
        issue_mem_data = md;
        #1;
    endtask

    task automatic idle();
        issue_valid = 0;
        issue_instr = 0;
        issue_id    = 0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".count"},  64'(count), 0);
        check({tag, ".enable"}, 64'(enable), 0);
        check({tag, ".instr"},  64'(instruction), 0);
        check({tag, ".id"},     64'(id), 0);
        check({tag, ".xreg"},   64'(data_fromXreg), 0);
        check({tag, ".mem"},    64'(data_fromMem), 0);
        check({tag, ".accept"}, 64'(issue_accept), 0);
        check({tag, ".ready"},  64'(issue_ready), 1);
    endtask

    initial begin
        rst = 0; issue_valid = 0; issue_instr = 0; issue_id = 0;
        issue_rs1_data = 0; issue_mem_data = 0; flush = 0; fpu_ready = 0;
        step(); step();
        rst = 1; #1;
        check_reset_outputs("reset");

        // Single FLW-style offer, presented one cycle later.
        fpu_ready = 1;
        offer(32'h00202087, 4'd0, 32'h0000_1234, 32'h3F800000);
        check("s1.accept", 64'(issue_accept), 1);
        check("s1.enable_same", 64'(enable), 0);
        step(); idle();
        check("s1.enable", 64'(enable), 1);
        check("s1.instr", 64'(instruction), 64'h00202087);
        check("s1.mem", 64'(data_fromMem), 64'h3F800000);
        check("s1.xreg", 64'(data_fromXreg), 64'h1234);
        step();
        check("s1.count0", 64'(count), 0);
        check("s1.enable_off", 64'(enable), 0);

        // Back-to-back OP-FP then STORE-FP.
        offer(32'h002081D3, 4'd1, 32'hA, 32'h0);
        check("s2.accept1", 64'(issue_accept), 1);
        step();
        offer(32'h00302027, 4'd2, 32'hB, 32'h0);
        check("s2.accept2", 64'(issue_accept), 1);
        check("s2.en1", 64'(enable), 1);
        check("s2.instr1", 64'(instruction), 64'h002081D3);
        check("s2.id1", 64'(id), 1);
        step(); idle();
        check("s2.count_hold", 64'(count), 1);
        check("s2.en2", 64'(enable), 1);
        check("s2.instr2", 64'(instruction), 64'h00302027);
        check("s2.id2", 64'(id), 2);
        step();
        check("s2.count0", 64'(count), 0);

        // Integer ADDI is rejected.
        offer(32'h00000013, 4'd5, 32'h0, 32'h0);
        check("s3.accept", 64'(issue_accept), 0);
        step(); idle();
        check("s3.count", 64'(count), 0);
        check("s3.enable", 64'(enable), 0);

        // Fill to DEPTH with the FPU stalled; fifth offer refused.
        fpu_ready = 0;
        for (int i = 0; i < 5; i++) begin
            offer(32'h00000053 | (32'(i) << 7), 4'(i + 3), 32'(i), 32'h100 + 32'(i));
            if (i < 4) check("s4.accept", 64'(issue_accept), 1);
            else begin
                check("s4.ready_full", 64'(issue_ready), 0);
                check("s4.accept5", 64'(issue_accept), 0);
                check("s4.count_full", 64'(count), 4);
                check("s4.enable_stall", 64'(enable), 0);
                check("s4.head_stable", 64'(instruction), 64'h00000053);
            end
            step();
        end
        idle();
        check("s4.count_after5", 64'(count), 4);
        fpu_ready = 1; #1;
        for (int i = 0; i < 4; i++) begin
            check("s4.drain_en", 64'(enable), 1);
            check("s4.drain_instr", 64'(instruction), 64'h00000053 | (64'(i) << 7));
            check("s4.drain_id", 64'(id), 64'(i + 3));
            check("s4.drain_mem", 64'(data_fromMem), 64'h100 + 64'(i));
            step();
        end
        check("s4.count0", 64'(count), 0);

        // Flush with count=3 beats a simultaneous push and pop.
        fpu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h00000007 | (32'(i) << 12), 4'(i), 32'h0, 32'h0);
            step();
        end
        check("s5.count3", 64'(count), 3);
        flush = 1; fpu_ready = 1;
        offer(32'h00000043, 4'd9, 32'h0, 32'h0);
        check("s5.accept", 64'(issue_accept), 0);
        check("s5.enable", 64'(enable), 0);
        check("s5.ready", 64'(issue_ready), 0);
        step();
        flush = 0; idle();
        check("s5.count0", 64'(count), 0);
        check("s5.enable_after", 64'(enable), 0);

        // Reset mid-operation with two entries held.
        fpu_ready = 0;
        for (int i = 0; i < 2; i++) begin
            offer(32'h0000004F | (32'(i) << 20), 4'(i + 7), 32'h55, 32'h66);
            step();
        end
        idle();
        check("s6.count2", 64'(count), 2);
        rst = 0;
        step();
        rst = 1; fpu_ready = 1; #1;
        check_reset_outputs("s6");
        for (int i = 0; i < 3; i++) begin
            step();
            check("s6.no_stale", 64'(enable), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/rvfpm_issue_queue.md
RVFPM_ISSUE_QUEUE -- requirements
Module: rvfpm_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered offload entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, meaning the integer operand width.
REQ-003 SHALL have parameter X_ID_WIDTH, default 4, meaning the instruction tag width.
REQ-004 SHALL have port ck, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit, a synchronous active-low reset.
REQ-006 SHALL have issue_valid, input, 1: core offers an instruction.
REQ-007 SHALL have issue_ready, output, 1: queue can take the offer this cycle.
REQ-008 SHALL have issue_instr, input, 32: raw instruction word.
REQ-009 SHALL have issue_id, input, X_ID_WIDTH: instruction tag.
REQ-010 SHALL have issue_rs1_data, input, XLEN: integer-register operand.
REQ-011 SHALL have issue_mem_data, input, 32: memory load data.
REQ-012 SHALL have issue_accept, output, 1: same-cycle verdict, 1 = FP instruction enqueued, 0 = rejected.
REQ-013 SHALL have flush, input, 1: discard all buffered entries.
REQ-014 SHALL have fpu_ready, input, 1: the FPU can take an instruction.
REQ-015 SHALL have enable, output, 1: an instruction is presented to the FPU.
REQ-016 SHALL have instruction, output, 32: word driven to the FPU.
REQ-017 SHALL have id, output, X_ID_WIDTH: tag driven to the FPU.
REQ-018 SHALL have data_fromXreg, output, XLEN: rs1 operand driven to the FPU.
REQ-019 SHALL have data_fromMem, output, 32: memory data driven to the FPU.
REQ-020 SHALL have count, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-021 SHALL treat an instruction as FP when opcode bits [6:0] are 0000111, 0100111, 1010011, 1000011, 1000111, 1001011 or 1001111.
REQ-022 SHALL compute issue_ready = (count < DEPTH) && !flush, with no same-cycle bypass on pop.
REQ-023 SHALL perform a push only when issue_valid && issue_ready && the opcode is FP.
REQ-024 SHALL drive issue_accept high exactly when a push occurs, and low otherwise.
REQ-025 SHALL not enqueue a non-FP offer; no state change results from it.
REQ-026 SHALL drive enable = (count != 0) && fpu_ready && !flush, combinationally.
REQ-027 SHALL drive instruction, id, data_fromXreg and data_fromMem from the head entry whenever count != 0, and zero when the queue is empty.
REQ-028 SHALL pop the head entry in every cycle where enable is high, so each entry is presented with enable high for exactly one cycle.
REQ-029 SHALL have minimum latency of 1 cycle: an entry pushed at edge N is presentable in the cycle after edge N.
REQ-030 SHALL apply a simultaneous push and pop in the same edge, leaving count unchanged.
REQ-031 SHALL deliver entries in strict FIFO order; read and write pointers wrap modulo DEPTH.
REQ-032 SHALL give flush priority over push and pop: count becomes 0, pointers return to 0, and no entry is popped or pushed in that cycle.
REQ-033 SHALL keep enable low while fpu_ready is low and hold the head outputs stable.

Reset
REQ-034 SHALL, when rst is low at a rising edge, set count to 0 and both pointers to 0.
REQ-035 SHALL produce, after reset, enable=0, instruction=0, id=0, data_fromXreg=0, data_fromMem=0, issue_accept=0 and issue_ready=1.
REQ-036 SHALL drop buffered entries on reset mid-operation, without presenting any of them.
REQ-037 SHALL not require entry storage RAM to be reset.

Structure
REQ-038 SHALL place the following in shared package rvfpm_pkg:
- X_ID_WIDTH default
- the seven FP opcode constants
- packed struct issue_entry_t {instr, id, rs1_data, mem_data}
REQ-039 SHALL instantiate one sub-module, rvfpm_fifo: a generic synchronous FIFO of issue_entry_t with push, pop, flush and count.

Verification
REQ-040 SHALL cover this scenario: offer instr 0x00202087 with mem_data 0x3F800000 and fpu_ready=1. Required response: issue_accept=1 that cycle; next cycle enable=1, instruction=0x00202087, data_fromMem=0x3F800000; count returns to 0.
REQ-041 SHALL cover this scenario: offer 0x002081D3 (OP-FP add) then 0x00302027 (STORE-FP) back-to-back. Required response: both appear at the FPU in order on consecutive cycles with their ids 1 and 2.
REQ-042 SHALL cover this scenario: offer 0x00000013 (integer ADDI). Required response: issue_accept=0, count stays 0, enable stays 0.
REQ-043 SHALL cover this scenario: fpu_ready=0 while 5 FP offers are made with DEPTH=4. Required response: 4 are accepted; then issue_ready=0 and count=4; the 5th is not accepted. After raising fpu_ready, the 4 entries drain in order across 4 cycles.
REQ-044 SHALL cover this scenario: count=3, then flush asserted together with a valid FP offer and fpu_ready=1. Required response: issue_accept=0 and enable=0 that cycle; count=0 on the next cycle.
REQ-045 SHALL cover this scenario: rst driven low for one edge while count=2. Required response: all outputs per REQ-035 next cycle, and no stale entry is ever presented.
